// File: rtl/dijkstra_mem_arbiter_pkg.sv
// Shared types and constants for the BlockRam arbiter between the host loader and DijkstraTop.
// Holds the default widths, the port indices and the FSM state encoding.
package dijkstra_mem_arbiter_pkg;

    localparam int DEFAULT_MADDR_WIDTH    = 16;
    localparam int DEFAULT_MDATA_WIDTH    = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Port indices double as bit positions in the one-hot grant vector.
    localparam logic PORT_HOST = 1'b0;
    localparam logic PORT_DIJ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN_HOST = 2'd1,
        ST_OWN_DIJ  = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DIJ) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dijkstra_mem_arbiter_if.sv
// Point-to-point memory request/response bundle used for the host, DijkstraTop and BlockRam links.
// The master issues enables/address/data; the slave answers with readies and read data.
interface dijkstra_mem_arbiter_if
    import dijkstra_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_MADDR_WIDTH,
    parameter int DATA_W = DEFAULT_MDATA_WIDTH
);

    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              read_ready;
    logic              write_ready;
    logic [DATA_W-1:0] read_data;

    modport master (
        output read_enable, write_enable, addr, write_data,
        input  read_ready, write_ready, read_data
    );

    modport slave (
        input  read_enable, write_enable, addr, write_data,
        output read_ready, write_ready, read_data
    );

endinterface

// File: rtl/dijkstra_mem_arbiter_rr_pick2.sv
// Two-request round-robin selector: a lone request wins, a tie goes to the port not granted last.
// Purely combinational; the caller registers the winner.
module dijkstra_mem_arbiter_rr_pick2
    import dijkstra_mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last_grant == PORT_HOST) ? port_onehot(PORT_DIJ)
                                                           : port_onehot(PORT_HOST);
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dijkstra_mem_arbiter.sv
// Shares the single BlockRam port between the host loader and DijkstraTop under round-robin,
// holding each grant until memory ready (or timeout) and stalling DijkstraTop while the host owns it.
module dijkstra_mem_arbiter
    import dijkstra_mem_arbiter_pkg::*;
#(
    parameter int MADDR_WIDTH    = DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH    = DEFAULT_MDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_host_lock,
    dijkstra_mem_arbiter_if.slave         host_port,
    dijkstra_mem_arbiter_if.slave         dij_port,
    dijkstra_mem_arbiter_if.master        mem_port,
    output logic                          o_dij_wait_request,
    output logic [1:0]                    o_grant,
    output logic                          o_fault
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_count;
    logic              r_fault;

    logic              w_host_req;
    logic              w_dij_req;
    logic              w_dij_eligible;
    logic [1:0]        w_pick;
    logic              w_own_host;
    logic              w_own_dij;
    logic              w_owned;
    logic              w_mem_done;
    logic              w_timeout;
    logic              w_both_en;

    logic              w_sel_re;
    logic              w_sel_we;
    logic [MADDR_WIDTH-1:0] w_sel_addr;
    logic [MDATA_WIDTH-1:0] w_sel_wdata;

    logic [1:0]        w_grant;
    logic              w_mem_re;
    logic              w_mem_we;
    logic [MADDR_WIDTH-1:0] w_mem_addr;
    logic [MDATA_WIDTH-1:0] w_mem_wdata;

    assign w_host_req     = host_port.read_enable | host_port.write_enable;
    assign w_dij_req      = dij_port.read_enable  | dij_port.write_enable;
    assign w_dij_eligible = w_dij_req & ~i_host_lock;

    dijkstra_mem_arbiter_rr_pick2 u_pick (
        .i_req        ({w_dij_eligible, w_host_req}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick)
    );

    assign w_own_host = (r_state == ST_OWN_HOST);
    assign w_own_dij  = (r_state == ST_OWN_DIJ);
    assign w_owned    = w_own_host | w_own_dij;

    // Owner's request lines, zero when nobody holds the memory.
    always_comb begin
        w_sel_re    = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        if (w_own_host) begin
            w_sel_re    = host_port.read_enable;
            w_sel_we    = host_port.write_enable;
            w_sel_addr  = host_port.addr;
            w_sel_wdata = host_port.write_data;
        end else if (w_own_dij) begin
            w_sel_re    = dij_port.read_enable;
            w_sel_we    = dij_port.write_enable;
            w_sel_addr  = dij_port.addr;
            w_sel_wdata = dij_port.write_data;
        end
    end

    assign w_mem_done = mem_port.read_ready | mem_port.write_ready;
    // A ready arriving on the last allowed cycle still completes normally.
    assign w_timeout  = w_owned & (r_count == CNT_MAX) & ~w_mem_done;
    assign w_both_en  = w_owned & w_sel_re & w_sel_we;

    always_comb begin
        w_next_state = r_state;
        w_grant      = 2'b00;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick == port_onehot(PORT_HOST)) begin
                    w_next_state = ST_OWN_HOST;
                end else if (w_pick == port_onehot(PORT_DIJ)) begin
                    w_next_state = ST_OWN_DIJ;
                end
            end
            ST_OWN_HOST, ST_OWN_DIJ: begin
                w_grant     = w_own_dij ? port_onehot(PORT_DIJ) : port_onehot(PORT_HOST);
                // A simultaneous read+write forwards only the write.
                w_mem_we    = w_sel_we;
                w_mem_re    = w_sel_re & ~w_sel_we;
                w_mem_addr  = w_sel_addr;
                w_mem_wdata = w_sel_wdata;
                if (w_mem_done || w_timeout) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT_DIJ;
            r_count      <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_owned) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= '0;
            end
            if (w_owned && (w_next_state == ST_RELEASE)) begin
                r_last_grant <= w_own_dij ? PORT_DIJ : PORT_HOST;
            end
            if (w_both_en || w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign mem_port.read_enable  = w_mem_re;
    assign mem_port.write_enable = w_mem_we;
    assign mem_port.addr         = w_mem_addr;
    assign mem_port.write_data   = w_mem_wdata;

    assign host_port.read_ready  = w_own_host & mem_port.read_ready;
    assign host_port.write_ready = w_own_host & mem_port.write_ready;
    assign host_port.read_data   = w_own_host ? mem_port.read_data : '0;

    assign dij_port.read_ready   = w_own_dij & mem_port.read_ready;
    assign dij_port.write_ready  = w_own_dij & mem_port.write_ready;
    assign dij_port.read_data    = w_own_dij ? mem_port.read_data : '0;

    assign o_grant            = w_grant;
    assign o_fault            = r_fault;
    assign o_dij_wait_request = i_host_lock | w_grant[PORT_HOST] | (w_dij_req & ~w_grant[PORT_DIJ]);

endmodule

// File: tb/tb_dijkstra_mem_arbiter.sv
// Directed bench for dijkstra_mem_arbiter with a one-cycle-latency BlockRam model that can stall.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_dijkstra_mem_arbiter;
    import dijkstra_mem_arbiter_pkg::*;

    localparam int AW = DEFAULT_MADDR_WIDTH;
    localparam int DW = DEFAULT_MDATA_WIDTH;
    localparam int TO = DEFAULT_TIMEOUT_CYCLES;

    logic       clock = 1'b0;
    logic       reset;
    logic       host_lock;
    logic       dij_wait;
    logic [1:0] grant;
    logic       fault;

    dijkstra_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host_bus ();
    dijkstra_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dij_bus ();
    dijkstra_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    dijkstra_mem_arbiter #(
        .MADDR_WIDTH    (AW),
        .MDATA_WIDTH    (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock            (clock),
        .i_reset            (reset),
        .i_host_lock        (host_lock),
        .host_port          (host_bus),
        .dij_port           (dij_bus),
        .mem_port           (mem_bus),
        .o_dij_wait_request (dij_wait),
        .o_grant            (grant),
        .o_fault            (fault)
    );

    always #5 clock = ~clock;

    // BlockRam model: one-cycle ready pulse per request unless stalled.
    logic [DW-1:0] mem_array [0:255];
    logic          mem_stall;

    always @(posedge clock) begin
        if (reset) begin
            mem_bus.read_ready  <= 1'b0;
            mem_bus.write_ready <= 1'b0;
            mem_bus.read_data   <= '0;
        end else begin
            mem_bus.write_ready <= mem_bus.write_enable & ~mem_bus.write_ready & ~mem_stall;
            mem_bus.read_ready  <= mem_bus.read_enable & ~mem_bus.read_ready & ~mem_stall;
            if (mem_bus.write_enable && !mem_bus.write_ready && !mem_stall) begin
                mem_array[mem_bus.addr[7:0]] <= mem_bus.write_data;
            end
            mem_bus.read_data <= mem_array[mem_bus.addr[7:0]];
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit port, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            dij_bus.read_enable  = rd;
            dij_bus.write_enable = wr;
            dij_bus.addr         = a;
            dij_bus.write_data   = d;
        end else begin
            host_bus.read_enable  = rd;
            host_bus.write_enable = wr;
            host_bus.addr         = a;
            host_bus.write_data   = d;
        end
    endtask

    function automatic logic rd_rdy(input bit port);
        return port ? dij_bus.read_ready : host_bus.read_ready;
    endfunction

    function automatic logic wr_rdy(input bit port);
        return port ? dij_bus.write_ready : host_bus.write_ready;
    endfunction

    function automatic logic [DW-1:0] rd_data(input bit port);
        return port ? dij_bus.read_data : host_bus.read_data;
    endfunction

    // One transaction on a port; drops enables on the ready cycle and watches three more cycles.
    task automatic access(input bit port, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int n_rd, output int n_wr, output logic [DW-1:0] rdata,
                          output int n_own, output int n_wait_low, output int n_mem_re);
        bit done;
        int tail;
        done = 1'b0;
        tail = 0;
        n_rd = 0; n_wr = 0; rdata = '0; n_own = 0; n_wait_low = 0; n_mem_re = 0;
        drive(port, rd, wr, a, d);
        for (int c = 0; c < 600 && tail < 3; c++) begin
            @(posedge clock); #1;
            if (grant == (port ? 2'b10 : 2'b01)) n_own++;
            if (!dij_wait) n_wait_low++;
            if (mem_bus.read_enable) n_mem_re++;
            if (rd_rdy(port)) begin
                n_rd++;
                rdata = rd_data(port);
            end
            if (wr_rdy(port)) n_wr++;
            if (done) tail++;
            else if (n_rd + n_wr > 0) begin
                done = 1'b1;
                drive(port, 1'b0, 1'b0, '0, '0);
            end
        end
        if (!done) drive(port, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    int            n_rd, n_wr, n_own, n_wait_low, n_mem_re;
    logic [DW-1:0] rdata;
    logic [1:0]    g_seq [$];
    logic [1:0]    prev_g;
    int            served, viol, lat, owned, rdy;
    bit            h_rearm, d_rearm, got;

    initial begin
        for (int i = 0; i < 256; i++) mem_array[i] = '0;
        reset     = 1'b1;
        host_lock = 1'b1;
        mem_stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        check("rst_grant", grant, 2'b00);
        check("rst_fault", fault, 1'b0);
        check("rst_mem_re", mem_bus.read_enable, 1'b0);
        check("rst_mem_we", mem_bus.write_enable, 1'b0);
        check("rst_mem_addr", mem_bus.addr, '0);
        check("rst_mem_wdata", mem_bus.write_data, '0);
        check("rst_host_rdy", {host_bus.read_ready, host_bus.write_ready}, 2'b00);
        check("rst_dij_rdy", {dij_bus.read_ready, dij_bus.write_ready}, 2'b00);
        check("rst_host_rdata", host_bus.read_data, '0);
        check("rst_wait_locked", dij_wait, 1'b1);
        host_lock = 1'b0;
        #1;
        check("rst_wait_unlocked", dij_wait, 1'b0);
        host_lock = 1'b1;
        reset = 1'b0;

        // Host-only write then read under host_lock
        access(1'b0, 1'b0, 1'b1, 16'h0008, 16'h1234, n_rd, n_wr, rdata, n_own, n_wait_low, n_mem_re);
        check("hwr_write_ready_pulses", n_wr, 1);
        check("hwr_read_ready_pulses", n_rd, 0);
        check("hwr_grant_cycles", n_own, 2);
        check("hwr_wait_low_cycles", n_wait_low, 0);
        access(1'b0, 1'b1, 1'b0, 16'h0008, 16'h0000, n_rd, n_wr, rdata, n_own, n_wait_low, n_mem_re);
        check("hrd_read_ready_pulses", n_rd, 1);
        check("hrd_data", rdata, 16'h1234);
        check("hrd_grant_cycles", n_own, 2);
        check("hrd_wait_low_cycles", n_wait_low, 0);

        // Tie alternation over four transactions from a fresh reset
        host_lock = 1'b0;
        pulse_reset();
        drive(1'b0, 1'b1, 1'b0, 16'h0008, '0);
        drive(1'b1, 1'b1, 1'b0, 16'h0008, '0);
        #1;
        check("tie_wait_idle", dij_wait, 1'b1);
        prev_g = 2'b00; served = 0; h_rearm = 1'b0; d_rearm = 1'b0;
        for (int c = 0; c < 200 && served < 4; c++) begin
            @(posedge clock); #1;
            if (grant != 2'b00 && prev_g == 2'b00) g_seq.push_back(grant);
            prev_g = grant;
            if (h_rearm) begin host_bus.read_enable = 1'b1; h_rearm = 1'b0; end
            if (d_rearm) begin dij_bus.read_enable = 1'b1; d_rearm = 1'b0; end
            if (host_bus.read_ready) begin host_bus.read_enable = 1'b0; h_rearm = 1'b1; served++; end
            if (dij_bus.read_ready) begin dij_bus.read_enable = 1'b0; d_rearm = 1'b1; served++; end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clock);
        #1;
        check("tie_served", served, 4);
        check("tie_grant0", g_seq[0], 2'b01);
        check("tie_grant1", g_seq[1], 2'b10);
        check("tie_grant2", g_seq[2], 2'b01);
        check("tie_grant3", g_seq[3], 2'b10);

        // host_lock blocks DijkstraTop, release grants promptly
        host_lock = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'h0008, '0);
        viol = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (grant == 2'b10 || dij_wait !== 1'b1) viol++;
        end
        check("lock_violations", viol, 0);
        host_lock = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); #1;
            if (grant == 2'b10) begin lat = c; break; end
        end
        check("lock_release_latency", lat, 1);
        check("lock_wait_in_own", dij_wait, 1'b0);
        got = 1'b0; rdata = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            if (dij_bus.read_ready) begin got = 1'b1; rdata = dij_bus.read_data; break; end
        end
        check("lock_dij_ready", got, 1'b1);
        check("lock_dij_data", rdata, 16'h1234);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clock);
        #1;

        // Simultaneous read+write from DijkstraTop
        check("rw_fault_before", fault, 1'b0);
        access(1'b1, 1'b1, 1'b1, 16'h0020, 16'hBEEF, n_rd, n_wr, rdata, n_own, n_wait_low, n_mem_re);
        check("rw_write_ready_pulses", n_wr, 1);
        check("rw_read_ready_pulses", n_rd, 0);
        check("rw_mem_re_cycles", n_mem_re, 0);
        check("rw_fault", fault, 1'b1);
        access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, n_rd, n_wr, rdata, n_own, n_wait_low, n_mem_re);
        check("rw_host_readback_pulses", n_rd, 1);
        check("rw_host_readback", rdata, 16'hBEEF);
        check("rw_fault_sticky", fault, 1'b1);

        // Timeout with a stalled memory
        pulse_reset();
        check("to_fault_cleared", fault, 1'b0);
        mem_stall = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 16'h0030, 16'h5555);
        owned = 0; rdy = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #1;
            if (grant == 2'b01) owned++;
            if (host_bus.read_ready || host_bus.write_ready) rdy++;
            if (owned > 0 && grant != 2'b01) break;
        end
        check("to_grant_cycles", owned, TO + 1);
        check("to_ready_pulses", rdy, 0);
        check("to_fault", fault, 1'b1);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); #1;
            if (grant == 2'b01) begin lat = c; break; end
        end
        check("to_regrant_latency", lat, 2);

        // Reset in the middle of the re-granted, still stalled access
        repeat (3) @(posedge clock);
        #1;
        check("mid_fault_sticky", fault, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("mid_grant", grant, 2'b00);
        check("mid_mem_re", mem_bus.read_enable, 1'b0);
        check("mid_mem_we", mem_bus.write_enable, 1'b0);
        check("mid_fault", fault, 1'b0);
        check("mid_host_ready", host_bus.write_ready, 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        mem_stall = 1'b0;
        reset     = 1'b0;
        @(posedge clock); #1;
        access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, n_rd, n_wr, rdata, n_own, n_wait_low, n_mem_re);
        check("post_reset_read_pulses", n_rd, 1);
        check("post_reset_read_data", rdata, 16'hBEEF);
        check("post_reset_grant_cycles", n_own, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
